// File: rtl/pll_tick_gen_if.sv
// Control and output bundle for pll_tick_gen; master drives lock/divider control, slave returns ticks.
// Combinational wiring only: no latency, no backpressure.
`timescale 1ns/1ps
interface pll_tick_gen_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              i_pll_locked;
  logic              i_div_wr;
  logic [SEL_W-1:0]  i_div_sel;
  logic [CNT_W-1:0]  i_div_val;
  logic              i_sync;
  logic [NUM_CH-1:0] o_tick;
  logic [NUM_CH-1:0] o_div_out;
  logic              o_rst_out;
  logic              o_ready;

  modport master (
    output i_pll_locked, i_div_wr, i_div_sel, i_div_val, i_sync,
    input  o_tick, o_div_out, o_rst_out, o_ready
  );

  modport slave (
    input  i_pll_locked, i_div_wr, i_div_sel, i_div_val, i_sync,
    output o_tick, o_div_out, o_rst_out, o_ready
  );
endinterface

// File: rtl/pll_tick_gen.sv
// Lock-qualified reset sequencer plus NUM_CH clock-enable dividers on the PLL output clock.
// All outputs registered (1 cycle); no backpressure, writes and sync are always accepted.
`timescale 1ns/1ps
module pll_tick_gen #(
  parameter int                        NUM_CH    = 3,
  parameter int                        CNT_W     = 16,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT  = {16'd0, 16'd2, 16'd4800},
  parameter int                        LOCK_FILT = 8,
  parameter int                        RST_HOLD  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pll_tick_gen_if.slave bus
);
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {S_WAIT, S_STABLE, S_HOLD, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_lk_meta, r_lk;
  logic [FILT_W-1:0]   r_filt, w_filt_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_rst_out, r_ready;
  logic                w_run;
  logic [NUM_CH-1:0]   w_tick, w_dout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lk_meta <= 1'b0;
      r_lk      <= 1'b0;
    end else begin
      r_lk_meta <= bus.i_pll_locked;
      r_lk      <= r_lk_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_WAIT;
      r_filt    <= '0;
      r_hold    <= '0;
      r_rst_out <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_filt    <= w_filt_nxt;
      r_hold    <= w_hold_nxt;
      r_rst_out <= (w_state_nxt != S_RUN);
      r_ready   <= (w_state_nxt == S_RUN);
    end
  end

  // The WAIT cycle that first sees lk counts as filter sample 0, so STABLE needs LOCK_FILT-1 more (LOCK_FILT >= 2).
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = r_filt;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_WAIT: begin
        if (r_lk) begin
          w_state_nxt = S_STABLE;
          w_filt_nxt  = '0;
        end
      end
      S_STABLE: begin
        if (!r_lk) begin
          w_state_nxt = S_WAIT;
        end else if (r_filt == FILT_W'(LOCK_FILT - 2)) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = '0;
        end else begin
          w_filt_nxt = r_filt + FILT_W'(1);
        end
      end
      S_HOLD: begin
        if (!r_lk) begin
          w_state_nxt = S_WAIT;
        end else if (r_hold == HOLD_W'(RST_HOLD - 1)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (!r_lk) begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  assign w_run = (r_state == S_RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt, r_act, r_shd;
    logic             r_tick, r_dout;
    logic [CNT_W-1:0] w_shd_nxt;
    logic             w_wr_hit, w_term;

    // Out-of-range selects never match any channel index, so they are dropped here.
    assign w_wr_hit  = bus.i_div_wr && (bus.i_div_sel == SEL_W'(c));
    assign w_shd_nxt = w_wr_hit ? bus.i_div_val : r_shd;
    assign w_term    = (r_cnt == r_act - CNT_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt  <= '0;
        r_act  <= DIV_INIT[c*CNT_W +: CNT_W];
        r_shd  <= DIV_INIT[c*CNT_W +: CNT_W];
        r_tick <= 1'b0;
        r_dout <= 1'b0;
      end else begin
        r_shd <= w_shd_nxt;
        if (!w_run || bus.i_sync || (r_act == '0)) begin
          r_cnt  <= '0;
          r_act  <= w_shd_nxt;
          r_tick <= 1'b0;
          r_dout <= 1'b0;
        end else begin
          r_tick <= w_term;
          r_dout <= (r_cnt < (r_act >> 1));
          if (w_term) begin
            r_cnt <= '0;
            r_act <= r_shd;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end

    assign w_tick[c] = r_tick;
    assign w_dout[c] = r_dout;
  end

  assign bus.o_tick    = w_tick;
  assign bus.o_div_out = w_dout;
  assign bus.o_rst_out = r_rst_out;
  assign bus.o_ready   = r_ready;
endmodule

// File: tb/tb_pll_tick_gen.sv
// Randomized and directed bench for pll_tick_gen against a cycle-time reference model.
`timescale 1ns/1ps
module tb_pll_tick_gen;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int LF     = 8;
  localparam int RH     = 16;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd0, 16'd2, 16'd4800};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pll_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  pll_tick_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT),
    .LOCK_FILT(LF), .RST_HOLD(RH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock history as a run length of high samples, channels as absolute period start times.
  int                n;
  int                run0, run1, run2;
  bit                m_ready;
  int                m_t0  [NUM_CH];
  int                m_act [NUM_CH];
  int                m_sh  [NUM_CH];
  logic [NUM_CH-1:0] m_tick, m_dout;

  task automatic model_reset();
    n = 0; run0 = 0; run1 = 0; run2 = 0; m_ready = 0;
    m_tick = '0; m_dout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = int'(DIV_INIT[c*CNT_W +: CNT_W]);
      m_sh[c]  = m_act[c];
      m_t0[c]  = 0;
    end
  endtask

  task automatic model_step();
    bit running;
    int shn, e;
    running = m_ready;
    n++;
    for (int c = 0; c < NUM_CH; c++) begin
      shn = (bus.i_div_wr && int'(bus.i_div_sel) == c) ? int'(bus.i_div_val) : m_sh[c];
      if (!running || bus.i_sync || m_act[c] == 0) begin
        m_t0[c] = n; m_tick[c] = 1'b0; m_dout[c] = 1'b0; m_act[c] = shn;
      end else begin
        e = n - 1 - m_t0[c];
        m_dout[c] = (e < m_act[c] / 2);
        m_tick[c] = (e == m_act[c] - 1);
        if (m_tick[c]) begin
          m_t0[c]  = n;
          m_act[c] = m_sh[c];
        end
      end
      m_sh[c] = shn;
    end
    run2 = run1; run1 = run0;
    run0 = bus.i_pll_locked ? run0 + 1 : 0;
    m_ready = (run2 >= LF + RH);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    chk("tick",    bus.o_tick,    m_tick);
    chk("div_out", bus.o_div_out, m_dout);
    chk("ready",   bus.o_ready,   m_ready);
    chk("rst_out", bus.o_rst_out, !m_ready);
    bus.i_div_wr = 1'b0;
    bus.i_sync   = 1'b0;
  endtask

  initial begin
    int k, down;
    rst = 1'b1;
    bus.i_pll_locked = 1'b1;
    bus.i_div_wr = 1'b0; bus.i_div_sel = '0; bus.i_div_val = '0; bus.i_sync = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_ready",   bus.o_ready,   0);
    chk("rst_rst_out", bus.o_rst_out, 1);
    chk("rst_tick",    bus.o_tick,    0);
    chk("rst_div_out", bus.o_div_out, 0);
    @(negedge clk);
    rst = 1'b0;

    k = 0;
    do begin cyc(); k++; end while (!bus.o_ready && k < 100);
    chk("lock_lat", k, 2 + LF + RH);

    bus.i_pll_locked = 1'b0; repeat (5) cyc();
    bus.i_pll_locked = 1'b1; repeat (6) cyc();
    bus.i_pll_locked = 1'b0; cyc();
    bus.i_pll_locked = 1'b1;
    k = 0;
    do begin cyc(); k++; end while (!bus.o_ready && k < 100);
    chk("relock_lat", k, 2 + LF + RH);

    k = 0;
    do begin cyc(); k++; end while (!bus.o_tick[0] && k < 6000);
    chk("ch0_first", k, 4800);
    k = 0;
    do begin cyc(); k++; end while (!bus.o_tick[0] && k < 6000);
    chk("ch0_period", k, 4800);
    k = 0;
    repeat (1000) begin cyc(); k++; end
    bus.i_div_wr = 1'b1; bus.i_div_sel = 2'd0; bus.i_div_val = 16'd100;
    do begin cyc(); k++; end while (!bus.o_tick[0] && k < 6000);
    chk("ch0_old_period", k, 4800);
    k = 0;
    do begin cyc(); k++; end while (!bus.o_tick[0] && k < 6000);
    chk("ch0_new_period", k, 100);

    bus.i_div_wr = 1'b1; bus.i_div_sel = 2'd2; bus.i_div_val = 16'd3;
    cyc();
    k = 0;
    do begin cyc(); k++; end while (!bus.o_tick[2] && k < 50);
    chk("ch2_first", k, 3);

    bus.i_div_wr = 1'b1; bus.i_div_sel = 2'd1; bus.i_div_val = 16'd3;
    cyc();
    bus.i_div_wr = 1'b1; bus.i_div_sel = 2'd0; bus.i_div_val = 16'd5; bus.i_sync = 1'b1;
    cyc();
    for (int r = 0; r < 2; r++) begin
      k = 0;
      do begin cyc(); k++; end while (!(bus.o_tick[0] && bus.o_tick[1]) && k < 100);
      chk("sync_coincide", k, 15);
    end

    bus.i_pll_locked = 1'b0;
    k = 0;
    do begin cyc(); k++; end while ((bus.o_ready || !bus.o_rst_out) && k < 10);
    chk("unlock_within3", (k <= 3), 1);
    cyc();
    chk("halt_tick",    bus.o_tick,    0);
    chk("halt_div_out", bus.o_div_out, 0);

    bus.i_pll_locked = 1'b1;
    down = 0;
    repeat (4000) begin
      if (down > 0) begin
        down--;
        bus.i_pll_locked = (down == 0);
      end else if ($urandom_range(0, 499) == 0) begin
        down = $urandom_range(1, 30);
        bus.i_pll_locked = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.i_div_wr  = 1'b1;
        bus.i_div_sel = 2'($urandom_range(0, 3));
        bus.i_div_val = 16'($urandom_range(0, 12));
      end
      bus.i_sync = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
